// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - shadow-scoreboard forwarding unit with load-use stall
module fwd_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  localparam int SW      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int SELW    = SW + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NSRC*REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_reg_we,
  input  logic                   id_mem_read,
  input  logic [1:0]             id_jump_t,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic [15:0]            stall_count
);

  localparam logic [1:0] KIND_RF   = 2'b00;
  localparam logic [1:0] KIND_ALU  = 2'b01;
  localparam logic [1:0] KIND_LINK = 2'b10;
  localparam logic [1:0] KIND_LOAD = 2'b11;

  // E[i] holds the instruction i+1 stages past ID
  logic              e_valid [DEPTH];
  logic [REG_AW-1:0] e_rd    [DEPTH];
  logic              e_we    [DEPTH];
  logic              e_load  [DEPTH];
  logic              e_link  [DEPTH];

  logic [NSRC-1:0]      hazard;
  logic [NSRC*SELW-1:0] next_sel;
  logic                 id_link;
  logic                 accept;

  assign id_link = (id_jump_t == 2'b01) || (id_jump_t == 2'b10);

  // Per-operand youngest-match search; scanning oldest to youngest lets the youngest overwrite
  always_comb begin
    hazard   = '0;
    next_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      logic [REG_AW-1:0] rs;
      logic [1:0]        kind;
      logic [SW-1:0]     stage;
      logic              hz;
      rs    = id_rs[k*REG_AW +: REG_AW];
      kind  = KIND_RF;
      stage = '0;
      hz    = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (e_valid[i] && e_we[i] && (e_rd[i] == rs) && (rs != '0)) begin
          stage = SW'(i);
          hz    = e_load[i] && (i < LOAD_LAT);
          if (e_link[i])
            kind = KIND_LINK;
          else if (e_load[i] && (i >= LOAD_LAT))
            kind = KIND_LOAD;
          else
            kind = KIND_ALU;
        end
      end
      hazard[k]                 = hz;
      next_sel[k*SELW +: SELW]  = {kind, stage};
    end
  end

  assign stall  = id_valid && !flush && (|hazard);
  assign accept = id_valid && !flush && !stall;

  // Advance the shadow pipeline; a rejected decode slot enters as a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_valid[i] <= 1'b0;
        e_rd[i]    <= '0;
        e_we[i]    <= 1'b0;
        e_load[i]  <= 1'b0;
        e_link[i]  <= 1'b0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        e_valid[i] <= e_valid[i-1];
        e_rd[i]    <= e_rd[i-1];
        e_we[i]    <= e_we[i-1];
        e_load[i]  <= e_load[i-1];
        e_link[i]  <= e_link[i-1];
      end
      e_valid[0] <= accept;
      e_rd[0]    <= id_rd;
      e_we[0]    <= id_reg_we;
      e_load[0]  <= id_mem_read;
      e_link[0]  <= id_link;
    end
  end

  // Register the selects so they line up with the consumer's EX cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fwd_sel <= '0;
    else if (accept)
      fwd_sel <= next_sel;
    else
      fwd_sel <= '0;
  end

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - table-driven bench for fwd_scoreboard
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst_n;

  logic        id_valid;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic        id_reg_we;
  logic        id_mem_read;
  logic [1:0]  id_jump_t;
  logic        flush;
  logic        stall;
  logic [7:0]  fwd_sel;
  logic [15:0] stall_count;

  logic        s_valid;
  logic [9:0]  s_rs;
  logic [4:0]  s_rd;
  logic        s_we;
  logic        s_mem;
  logic [1:0]  s_jt;
  logic        s_flush;
  logic        s_stall;
  logic [13:0] s_sel;
  logic [15:0] s_count;

  int n_checks;
  int n_pass;

  fwd_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_mem_read(id_mem_read), .id_jump_t(id_jump_t),
    .flush(flush), .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count)
  );

  fwd_scoreboard #(.DEPTH(32), .LOAD_LAT(31)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(s_valid), .id_rs(s_rs), .id_rd(s_rd),
    .id_reg_we(s_we), .id_mem_read(s_mem), .id_jump_t(s_jt),
    .flush(s_flush), .stall(s_stall), .fwd_sel(s_sel), .stall_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        mem;
    logic [1:0]  jt;
    logic        fl;
    logic        exp_stall;
    logic [7:0]  exp_sel;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[25];

  initial begin
    int cyc;
    int burst;

    n_checks = 0;
    n_pass   = 0;

    //           valid rs1 rs2 rd we mem jt fl  stall sel   cnt
    vecs[0]  = '{1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[1]  = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h04, 16'd0};
    vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[3]  = '{1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 16'd1};
    vecs[4]  = '{1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'hD0, 16'd1};
    vecs[5]  = '{1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[6]  = '{1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[7]  = '{1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h88, 16'd1};
    vecs[8]  = '{1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h09, 16'd1};
    vecs[9]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[10] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[11] = '{1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[12] = '{1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[13] = '{1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[14] = '{1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h04, 16'd1};
    vecs[15] = '{1'b1, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h50, 16'd1};
    vecs[16] = '{1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h06, 16'd1};
    vecs[17] = '{1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[18] = '{1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h04, 16'd1};
    vecs[19] = '{1'b0, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[20] = '{1'b1, 5'd8, 5'd0, 5'd4, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h06, 16'd1};
    vecs[21] = '{1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 16'd1};
    vecs[22] = '{1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h0D, 16'd1};
    vecs[23] = '{1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[24] = '{1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h80, 16'd1};

    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rd = '0; id_reg_we = 1'b0;
    id_mem_read = 1'b0; id_jump_t = 2'd0; flush = 1'b0;
    s_valid = 1'b0; s_rs = '0; s_rd = '0; s_we = 1'b0;
    s_mem = 1'b0; s_jt = 2'd0; s_flush = 1'b0;

    #2;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_fwd_sel", {24'd0, fwd_sel}, 32'd0);
    check("reset_stall_count", {16'd0, stall_count}, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      id_valid    = vecs[v].valid;
      id_rs       = {vecs[v].rs2, vecs[v].rs1};
      id_rd       = vecs[v].rd;
      id_reg_we   = vecs[v].we;
      id_mem_read = vecs[v].mem;
      id_jump_t   = vecs[v].jt;
      flush       = vecs[v].fl;
      #2;
      check($sformatf("vec%0d_stall", v), {31'd0, stall}, {31'd0, vecs[v].exp_stall});
      @(posedge clk); #1;
      check($sformatf("vec%0d_fwd_sel", v), {24'd0, fwd_sel}, {24'd0, vecs[v].exp_sel});
      check($sformatf("vec%0d_stall_count", v), {16'd0, stall_count}, {16'd0, vecs[v].exp_cnt});
    end

    // Reset asserted in the middle of a load-use stall
    id_valid = 1'b1; id_rs = '0; id_rd = 5'd7; id_reg_we = 1'b1;
    id_mem_read = 1'b1; id_jump_t = 2'd0; flush = 1'b0;
    @(posedge clk); #1;
    id_rs = {5'd0, 5'd7}; id_rd = 5'd0; id_reg_we = 1'b0; id_mem_read = 1'b0;
    #2;
    check("rst_seq_stall_before", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_seq_stall_during", {31'd0, stall}, 32'd0);
    check("rst_seq_fwd_sel_during", {24'd0, fwd_sel}, 32'd0);
    check("rst_seq_count_during", {16'd0, stall_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_seq_count_after", {16'd0, stall_count}, 32'd0);
    check("rst_seq_stall_after", {31'd0, stall}, 32'd0);
    id_valid = 1'b0;

    // Deep instance: back-to-back dependent loads stall LOAD_LAT cycles each
    s_valid = 1'b1; s_rs = {5'd0, 5'd7}; s_rd = 5'd7; s_we = 1'b1; s_mem = 1'b1;
    #2;
    check("sat_first_issue_stall", {31'd0, s_stall}, 32'd0);
    @(posedge clk); #1;
    burst = 0;
    while (s_stall && burst < 100) begin
      burst++;
      @(posedge clk); #1;
    end
    check("sat_burst_len", burst, 31);
    check("sat_count_after_burst", {16'd0, s_count}, 32'd31);

    cyc = 0;
    while (s_count != 16'hFFFF && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sat_reached_max", {16'd0, s_count}, 32'h0000FFFF);
    burst = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (s_stall) burst++;
    end
    check("sat_still_stalling", {31'd0, (burst > 0)}, 32'd1);
    check("sat_holds_max", {16'd0, s_count}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the combinational forwarding unit. Keeps its own shadow scoreboard of in-flight destination registers instead of taking rd/we from each pipeline register.
- Sits beside the ID stage. Issues a registered per-operand bypass select for the instruction entering EX, and a combinational load-use stall for PC/IF-ID.
- Generalised in operand count, forwarding depth and load latency. Adds flush handling and a stall performance counter.

Parameters:
- REG_AW, 5, register index width.
- NSRC, 2, source operands per instruction.
- DEPTH, 3, scoreboard entries, which is also the number of forwarding stages. Entry E[i] is the instruction i+1 stages past ID. Must be >= 2.
- LOAD_LAT, 1, number of youngest entries whose load data is not yet forwardable. Must be < DEPTH.
- SW, max(1,clog2(DEPTH)), stage-index width (derived).
- SELW, SW+2, select width per operand (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs  in  NSRC*REG_AW  source indices; operand k is at bits [k*REG_AW +: REG_AW].
- id_rd  in  REG_AW  destination index.
- id_reg_we  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- id_jump_t  in  2  00 none, 01 JAL, 10 JALR, 11 reserved (treated as none).
- flush  in  1  discard the decode-slot instruction (taken branch/jump).
- stall  out  1  combinational load-use stall.
- fwd_sel  out  NSRC*SELW  registered select per operand, {kind[1:0], stage[SW-1:0]}.
- stall_count  out  16  saturating count of stall cycles.

Behaviour:
- Entry fields: valid, rd, we, load, link. Link = jump_t is 01 or 10.
- Match of operand k against E[i]: E[i].valid & E[i].we & E[i].rd == rs_k & rs_k != 0.
- When an operand matches several entries, the lowest i (youngest) wins. No match gives kind 00, stage 0 (register file).
- Kind selection for the winning match at entry i:
  - link: kind 10 (producer PC+4), stage i.
  - load with i >= LOAD_LAT: kind 11 (load data), stage i.
  - otherwise: kind 01 (ALU result), stage i.
- Load-use hazard: the youngest match is a load with i < LOAD_LAT. An older load is irrelevant if a younger non-load matches.
- stall = id_valid & ~flush & (any operand has a load-use hazard). Combinational, no latency.
- Each rising clk (not in reset):
  - E[i] <= E[i-1] for i >= 1. Older entries always advance.
  - E[0] <= decode instruction if id_valid & ~stall & ~flush. Otherwise E[0] becomes a bubble (valid=0).
  - fwd_sel <= selects computed from id_rs against the current entries if id_valid & ~stall & ~flush. Otherwise all zero. fwd_sel is therefore valid during the consumer's EX cycle.
  - stall_count increments when stall=1. It holds at 16'hFFFF.
- Stall duration: LOAD_LAT - i cycles for a load at E[i]. It self-clears as the load advances; no explicit FSM state.
- flush together with a hazard: flush wins. stall=0 and a bubble is inserted.
- id_valid=0: stall=0, bubble inserted, fwd_sel cleared.
- Simultaneous match of a link entry and a younger ALU entry: the younger entry wins.
- Reset (asserted at any time, including mid-stall):
  - all entries invalid, fwd_sel=0, stall_count=0.
  - stall=0 immediately, since it derives from entries.
- id_jump_t=11 is treated as a non-link instruction.

Test Plan:
- Defaults, with SW=2 and SELW=4.
- ALU producer: issue rd=5, we=1; next cycle consumer rs1=5 -> stall=0; after the edge fwd_sel[3:0]=4'h4 (ALU, stage 0).
- Load-use: load rd=7; next cycle consumer rs2=7 -> stall=1 for exactly 1 cycle and stall_count=1; the following edge gives fwd_sel[7:4]=4'hD (load, stage 1).
- Priority: ALU to x3, then JAL rd=3, then consumer rs1=3 and rs2=3 -> both selects = 4'h8 (link, stage 0), not 4'h5.
- Zero register: producer rd=0, we=1, load=1; consumer rs1=0 -> stall=0 and fwd_sel=0. Also we=0 producer on rd=9 with consumer rs1=9 -> fwd_sel=0.
- Flush and reset:
  - load rd=4, consumer rs1=4 with flush=1 in the same cycle -> stall=0, E[0] bubble, fwd_sel=0.
  - separately, assert rst_n=0 during a stall -> stall drops immediately; after release, stall_count=0.
- Saturation: force 65540 stall cycles -> stall_count=16'hFFFF and holds there.
